xadc_pair_averager: RTL and testbench
=====================================

// Module: xadc_pair_averager
// PURPOSE
//  Sits directly downstream of the XADC mux-sampling front end. Consumes its
//  paired 12-bit coil samples (data_a, data_b) and their new_data strobe.
//  Boxcar-averages 2^LOG2_AVG pairs and presents avg_a, avg_b and signed
//  avg_a-avg_b through a valid/ready output with a sticky overrun flag.
// PARAMETERS
//  DATA_W    12  sample width of data_a/data_b
//  LOG2_AVG  4   log2 of pairs per average; legal 0..8 (0 = pass-through)
// PORTS
//  clk            in   1         system clock
//  rst_n          in   1         async active-low reset
//  enable         in   1         1 = accumulate; 0 = flush partial block
//  new_data       in   1         sample-pair strobe from front end (level ok)
//  data_a         in   DATA_W    channel A sample, valid when new_data high
//  data_b         in   DATA_W    channel B sample, valid when new_data high
//  avg_valid      out  1         result held on avg_* is valid
//  avg_ready      in   1         consumer accepts result this cycle
//  avg_a          out  DATA_W    mean of channel A over block
//  avg_b          out  DATA_W    mean of channel B over block
//  avg_diff       out  DATA_W+1  signed two's complement avg_a - avg_b
//  overrun        out  1         sticky: unaccepted result was overwritten
//  clear_overrun  in   1         synchronous clear of overrun
// BEHAVIOUR
//  Reset: clk is the only clock; rst_n=0 asynchronously zeroes all state:
//   accumulators, count, new_data_q, avg_valid, avg_a, avg_b, avg_diff,
//   overrun. State is ACCUM after release.
//  Event: new_data_q <= new_data; evt = new_data & ~new_data_q & enable.
//   data_a/data_b are captured in the evt cycle. A level held high counts once.
//  Accumulate: acc_a/acc_b are DATA_W+LOG2_AVG bits wide (cannot overflow).
//   cnt is LOG2_AVG bits. Each evt adds the samples and increments cnt.
//  Block end: an evt with cnt == 2^LOG2_AVG-1 completes the block.
//   Next edge: avg_a <= (acc_a+data_a)>>LOG2_AVG (truncate); same for avg_b.
//   Next edge: avg_diff <= {0,avg_a_new} - {0,avg_b_new}; avg_valid <= 1.
//   Next edge: acc and cnt <= 0. Latency is 1 clk from final evt to avg_valid.
//  Handshake: a transfer occurs when avg_valid & avg_ready.
//   avg_* stay stable while avg_valid & ~avg_ready.
//   On a transfer with no new result, avg_valid <= 0.
//  Simultaneous transfer and block end: the new result loads and avg_valid
//   stays 1. No overrun.
//  Block end while avg_valid & ~avg_ready: the new result overwrites the
//   output, avg_valid stays 1, and overrun <= 1.
//  overrun: the set condition beats clear_overrun in the same cycle.
//   Otherwise clear_overrun=1 clears it next edge.
//  enable=0: acc, cnt <= 0 each cycle and the partial block is discarded.
//   avg_*, avg_valid and overrun are unaffected.
//   On re-enable, counting starts at the next evt.
//  LOG2_AVG=0: every evt produces a result (registered pass-through).
//  avg_ready is ignored when avg_valid=0.
// TESTING
//  T1 LOG2_AVG=2: 4 pulses, A=100,101,102,103 and B=50 each
//     -> avg_valid 1 clk after 4th pulse; avg_a=101, avg_b=50, avg_diff=+51.
//  T2 A=0 and B=4095 for a full block -> avg_diff = -4095 (13'h1001).
//     Then A=B=4095 -> avg_a=avg_b=4095, avg_diff=0, with no overflow.
//  T3 new_data held high for 5 clks, repeated 4 times
//     -> exactly one result, using only the first-cycle samples of each pulse.
//  T4 avg_ready=0 through 2 blocks -> overrun=1 and second result visible.
//     Then clear_overrun together with a third block end -> overrun stays 1.
//     Then clear_overrun alone -> overrun=0.
//  T5 enable drops after 2 of 4 pulses, then 4 pulses of A=8
//     -> avg_a=8 (partial discarded).
//     Assert rst_n=0 mid-block -> all outputs 0 immediately, without a clk edge.
//  T6 avg_ready=1 in the same cycle a new block completes
//     -> avg_valid stays 1, new values loaded, overrun=0.

Source files
------------

// File: rtl/xadc_pair_averager_if.sv
// Sample-pair input and averaged-result valid/ready output bundle
// for the XADC pair averager.
interface xadc_pair_averager_if #(
  parameter int DATA_W = 12
);
  logic              new_data;
  logic [DATA_W-1:0] data_a;
  logic [DATA_W-1:0] data_b;
  logic              avg_valid;
  logic              avg_ready;
  logic [DATA_W-1:0] avg_a;
  logic [DATA_W-1:0] avg_b;
  logic [DATA_W:0]   avg_diff;

  modport master (
    input  new_data,
    input  data_a,
    input  data_b,
    input  avg_ready,
    output avg_valid,
    output avg_a,
    output avg_b,
    output avg_diff
  );

  modport slave (
    output new_data,
    output data_a,
    output data_b,
    output avg_ready,
    input  avg_valid,
    input  avg_a,
    input  avg_b,
    input  avg_diff
  );
endinterface

// File: rtl/xadc_pair_averager.sv
// Boxcar averager for paired XADC coil samples: sums 2^LOG2_AVG
// pairs, emits means and signed difference over valid/ready.
module xadc_pair_averager #(
  parameter int DATA_W   = 12,
  parameter int LOG2_AVG = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear_overrun,
  output logic overrun,
  xadc_pair_averager_if.master bus
);

  localparam int ACC_W = DATA_W + LOG2_AVG;
  localparam int CNT_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;
  localparam logic [CNT_W-1:0] LAST_CNT =
    CNT_W'((1 << LOG2_AVG) - 1);

  logic              new_data_q;
  logic [ACC_W-1:0]  acc_a_q, acc_a_d;
  logic [ACC_W-1:0]  acc_b_q, acc_b_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              avg_valid_q, avg_valid_d;
  logic [DATA_W-1:0] avg_a_q, avg_a_d;
  logic [DATA_W-1:0] avg_b_q, avg_b_d;
  logic [DATA_W:0]   avg_diff_q, avg_diff_d;
  logic              overrun_q, overrun_d;

  logic              evt;
  logic              blk_end;
  logic              xfer;
  logic [ACC_W-1:0]  sum_a;
  logic [ACC_W-1:0]  sum_b;

  // Next-state: rising-edge event, accumulation, result load, overrun.
  always_comb begin
    evt     = bus.new_data & ~new_data_q & enable;
    blk_end = evt & (cnt_q == LAST_CNT);
    xfer    = avg_valid_q & bus.avg_ready;
    sum_a   = acc_a_q + ACC_W'(bus.data_a);
    sum_b   = acc_b_q + ACC_W'(bus.data_b);

    acc_a_d     = acc_a_q;
    acc_b_d     = acc_b_q;
    cnt_d       = cnt_q;
    avg_valid_d = avg_valid_q;
    avg_a_d     = avg_a_q;
    avg_b_d     = avg_b_q;
    avg_diff_d  = avg_diff_q;
    overrun_d   = overrun_q;

    if (!enable) begin
      acc_a_d = '0;
      acc_b_d = '0;
      cnt_d   = '0;
    end else if (blk_end) begin
      acc_a_d = '0;
      acc_b_d = '0;
      cnt_d   = '0;
    end else if (evt) begin
      acc_a_d = sum_a;
      acc_b_d = sum_b;
      cnt_d   = cnt_q + CNT_W'(1);
    end

    if (blk_end) begin
      avg_a_d     = DATA_W'(sum_a >> LOG2_AVG);
      avg_b_d     = DATA_W'(sum_b >> LOG2_AVG);
      avg_diff_d  = {1'b0, avg_a_d} - {1'b0, avg_b_d};
      avg_valid_d = 1'b1;
    end else if (xfer) begin
      avg_valid_d = 1'b0;
    end

    if (blk_end & avg_valid_q & ~bus.avg_ready) begin
      overrun_d = 1'b1;
    end else if (clear_overrun) begin
      overrun_d = 1'b0;
    end
  end

  // State registers, all cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      new_data_q  <= 1'b0;
      acc_a_q     <= '0;
      acc_b_q     <= '0;
      cnt_q       <= '0;
      avg_valid_q <= 1'b0;
      avg_a_q     <= '0;
      avg_b_q     <= '0;
      avg_diff_q  <= '0;
      overrun_q   <= 1'b0;
    end else begin
      new_data_q  <= bus.new_data;
      acc_a_q     <= acc_a_d;
      acc_b_q     <= acc_b_d;
      cnt_q       <= cnt_d;
      avg_valid_q <= avg_valid_d;
      avg_a_q     <= avg_a_d;
      avg_b_q     <= avg_b_d;
      avg_diff_q  <= avg_diff_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.avg_valid = avg_valid_q;
  assign bus.avg_a     = avg_a_q;
  assign bus.avg_b     = avg_b_q;
  assign bus.avg_diff  = avg_diff_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_xadc_pair_averager.sv
// Directed bench for xadc_pair_averager: LOG2_AVG=2 main instance
// plus a LOG2_AVG=0 pass-through instance sharing the inputs.
module tb_xadc_pair_averager;

  localparam int DW = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic clear_overrun = 1'b0;
  logic ovr2;
  logic ovr0;

  int tests = 0;
  int fails = 0;

  xadc_pair_averager_if #(.DATA_W(DW)) s_if ();
  xadc_pair_averager_if #(.DATA_W(DW)) p_if ();

  always #5 clk = ~clk;

  assign p_if.new_data  = s_if.new_data;
  assign p_if.data_a    = s_if.data_a;
  assign p_if.data_b    = s_if.data_b;
  assign p_if.avg_ready = 1'b1;

  xadc_pair_averager #(.DATA_W(DW), .LOG2_AVG(2)) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .clear_overrun (clear_overrun),
    .overrun       (ovr2),
    .bus           (s_if.master)
  );

  xadc_pair_averager #(.DATA_W(DW), .LOG2_AVG(0)) u_pass (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .clear_overrun (clear_overrun),
    .overrun       (ovr0),
    .bus           (p_if.master)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic clr);
    s_if.new_data = 1'b1;
    s_if.data_a   = a;
    s_if.data_b   = b;
    clear_overrun = clr;
    step();
    s_if.new_data = 1'b0;
    clear_overrun = 1'b0;
    step();
  endtask

  task automatic hold5(input logic [DW-1:0] a, input logic [DW-1:0] b);
    s_if.new_data = 1'b1;
    s_if.data_a   = a;
    s_if.data_b   = b;
    step();
    s_if.data_a = 12'd4000;
    s_if.data_b = 12'd4000;
    repeat (4) step();
    s_if.new_data = 1'b0;
    step();
  endtask

  task automatic drain();
    s_if.avg_ready = 1'b1;
    step();
    s_if.avg_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    enable = 1'b1;
    repeat (3) step();
    tests++; if (s_if.avg_valid !== 1'b0) begin fails++;
      $display("FAIL rst_valid: got %0d expected 0", s_if.avg_valid); end
    tests++; if (s_if.avg_a !== 12'd0) begin fails++;
      $display("FAIL rst_avg_a: got %0d expected 0", s_if.avg_a); end
    tests++; if (s_if.avg_diff !== 13'd0) begin fails++;
      $display("FAIL rst_diff: got %0d expected 0", s_if.avg_diff); end
    tests++; if (ovr2 !== 1'b0) begin fails++;
      $display("FAIL rst_overrun: got %0d expected 0", ovr2); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    pulse(12'd100, 12'd50, 1'b0);
    pulse(12'd101, 12'd50, 1'b0);
    pulse(12'd102, 12'd50, 1'b0);
    tests++; if (s_if.avg_valid !== 1'b0) begin fails++;
      $display("FAIL t1_early_valid: got %0d expected 0", s_if.avg_valid); end
    s_if.new_data = 1'b1;
    s_if.data_a   = 12'd103;
    s_if.data_b   = 12'd50;
    step();
    tests++; if (s_if.avg_valid !== 1'b1) begin fails++;
      $display("FAIL t1_latency: got %0d expected 1", s_if.avg_valid); end
    tests++; if (s_if.avg_a !== 12'd101) begin fails++;
      $display("FAIL t1_avg_a: got %0d expected 101", s_if.avg_a); end
    tests++; if (s_if.avg_b !== 12'd50) begin fails++;
      $display("FAIL t1_avg_b: got %0d expected 50", s_if.avg_b); end
    tests++; if (s_if.avg_diff !== 13'd51) begin fails++;
      $display("FAIL t1_diff: got %0d expected 51", s_if.avg_diff); end
    s_if.new_data = 1'b0;
    step();
    drain();
    step();
    tests++; if (s_if.avg_valid !== 1'b0) begin fails++;
      $display("FAIL t1_drained: got %0d expected 0", s_if.avg_valid); end
  endtask

  task automatic test_extremes();
    repeat (4) pulse(12'd0, 12'd4095, 1'b0);
    tests++; if (s_if.avg_b !== 12'd4095) begin fails++;
      $display("FAIL t2_avg_b: got %0d expected 4095", s_if.avg_b); end
    tests++; if (s_if.avg_diff !== 13'h1001) begin fails++;
      $display("FAIL t2_neg_diff: got %0h expected 1001", s_if.avg_diff); end
    drain();
    repeat (4) pulse(12'd4095, 12'd4095, 1'b0);
    tests++; if (s_if.avg_a !== 12'd4095) begin fails++;
      $display("FAIL t2_full_a: got %0d expected 4095", s_if.avg_a); end
    tests++; if (s_if.avg_b !== 12'd4095) begin fails++;
      $display("FAIL t2_full_b: got %0d expected 4095", s_if.avg_b); end
    tests++; if (s_if.avg_diff !== 13'd0) begin fails++;
      $display("FAIL t2_zero_diff: got %0d expected 0", s_if.avg_diff); end
    drain();
  endtask

  task automatic test_held_level();
    hold5(12'd10, 12'd1);
    hold5(12'd20, 12'd2);
    hold5(12'd30, 12'd3);
    tests++; if (s_if.avg_valid !== 1'b0) begin fails++;
      $display("FAIL t3_one_evt: got %0d expected 0", s_if.avg_valid); end
    hold5(12'd40, 12'd4);
    tests++; if (s_if.avg_valid !== 1'b1) begin fails++;
      $display("FAIL t3_valid: got %0d expected 1", s_if.avg_valid); end
    tests++; if (s_if.avg_a !== 12'd25) begin fails++;
      $display("FAIL t3_avg_a: got %0d expected 25", s_if.avg_a); end
    tests++; if (s_if.avg_b !== 12'd2) begin fails++;
      $display("FAIL t3_avg_b: got %0d expected 2", s_if.avg_b); end
    tests++; if (s_if.avg_diff !== 13'd23) begin fails++;
      $display("FAIL t3_diff: got %0d expected 23", s_if.avg_diff); end
    drain();
  endtask

  task automatic test_overrun();
    s_if.avg_ready = 1'b0;
    repeat (4) pulse(12'd4, 12'd4, 1'b0);
    tests++; if (ovr2 !== 1'b0) begin fails++;
      $display("FAIL t4_no_ovr: got %0d expected 0", ovr2); end
    repeat (4) pulse(12'd8, 12'd2, 1'b0);
    tests++; if (ovr2 !== 1'b1) begin fails++;
      $display("FAIL t4_ovr_set: got %0d expected 1", ovr2); end
    tests++; if (s_if.avg_a !== 12'd8) begin fails++;
      $display("FAIL t4_second_a: got %0d expected 8", s_if.avg_a); end
    tests++; if (s_if.avg_diff !== 13'd6) begin fails++;
      $display("FAIL t4_second_diff: got %0d expected 6", s_if.avg_diff); end
    repeat (3) pulse(12'd12, 12'd0, 1'b0);
    pulse(12'd12, 12'd0, 1'b1);
    tests++; if (ovr2 !== 1'b1) begin fails++;
      $display("FAIL t4_set_beats_clr: got %0d expected 1", ovr2); end
    tests++; if (s_if.avg_a !== 12'd12) begin fails++;
      $display("FAIL t4_third_a: got %0d expected 12", s_if.avg_a); end
    clear_overrun = 1'b1;
    step();
    clear_overrun = 1'b0;
    tests++; if (ovr2 !== 1'b0) begin fails++;
      $display("FAIL t4_clr: got %0d expected 0", ovr2); end
    tests++; if (s_if.avg_valid !== 1'b1) begin fails++;
      $display("FAIL t4_still_valid: got %0d expected 1", s_if.avg_valid); end
    drain();
  endtask

  task automatic test_enable_and_async_reset();
    pulse(12'd100, 12'd0, 1'b0);
    pulse(12'd100, 12'd0, 1'b0);
    enable = 1'b0;
    repeat (2) step();
    enable = 1'b1;
    step();
    repeat (3) pulse(12'd8, 12'd0, 1'b0);
    tests++; if (s_if.avg_valid !== 1'b0) begin fails++;
      $display("FAIL t5_partial_kept: got %0d expected 0", s_if.avg_valid); end
    pulse(12'd8, 12'd0, 1'b0);
    tests++; if (s_if.avg_a !== 12'd8) begin fails++;
      $display("FAIL t5_avg_a: got %0d expected 8", s_if.avg_a); end
    tests++; if (s_if.avg_diff !== 13'd8) begin fails++;
      $display("FAIL t5_diff: got %0d expected 8", s_if.avg_diff); end
    pulse(12'd50, 12'd50, 1'b0);
    pulse(12'd50, 12'd50, 1'b0);
    rst_n = 1'b0;
    #1;
    tests++; if (s_if.avg_valid !== 1'b0) begin fails++;
      $display("FAIL t5_async_valid: got %0d expected 0", s_if.avg_valid); end
    tests++; if (s_if.avg_a !== 12'd0) begin fails++;
      $display("FAIL t5_async_a: got %0d expected 0", s_if.avg_a); end
    tests++; if (s_if.avg_diff !== 13'd0) begin fails++;
      $display("FAIL t5_async_diff: got %0d expected 0", s_if.avg_diff); end
    step();
    rst_n = 1'b1;
    step();
    repeat (4) pulse(12'd20, 12'd4, 1'b0);
    tests++; if (s_if.avg_a !== 12'd20) begin fails++;
      $display("FAIL t5_post_rst_a: got %0d expected 20", s_if.avg_a); end
    tests++; if (s_if.avg_diff !== 13'd16) begin fails++;
      $display("FAIL t5_post_rst_diff: got %0d expected 16", s_if.avg_diff); end
    drain();
  endtask

  task automatic test_back_to_back();
    s_if.avg_ready = 1'b0;
    repeat (4) pulse(12'd40, 12'd40, 1'b0);
    repeat (3) pulse(12'd60, 12'd20, 1'b0);
    s_if.new_data  = 1'b1;
    s_if.data_a    = 12'd60;
    s_if.data_b    = 12'd20;
    s_if.avg_ready = 1'b1;
    step();
    s_if.new_data  = 1'b0;
    s_if.avg_ready = 1'b0;
    tests++; if (s_if.avg_valid !== 1'b1) begin fails++;
      $display("FAIL t6_valid: got %0d expected 1", s_if.avg_valid); end
    tests++; if (s_if.avg_a !== 12'd60) begin fails++;
      $display("FAIL t6_avg_a: got %0d expected 60", s_if.avg_a); end
    tests++; if (s_if.avg_diff !== 13'd40) begin fails++;
      $display("FAIL t6_diff: got %0d expected 40", s_if.avg_diff); end
    tests++; if (ovr2 !== 1'b0) begin fails++;
      $display("FAIL t6_no_ovr: got %0d expected 0", ovr2); end
    step();
    drain();
  endtask

  task automatic test_passthrough();
    s_if.new_data = 1'b1;
    s_if.data_a   = 12'd7;
    s_if.data_b   = 12'd9;
    step();
    s_if.new_data = 1'b0;
    tests++; if (p_if.avg_valid !== 1'b1) begin fails++;
      $display("FAIL pt_valid: got %0d expected 1", p_if.avg_valid); end
    tests++; if (p_if.avg_a !== 12'd7) begin fails++;
      $display("FAIL pt_avg_a: got %0d expected 7", p_if.avg_a); end
    tests++; if (p_if.avg_b !== 12'd9) begin fails++;
      $display("FAIL pt_avg_b: got %0d expected 9", p_if.avg_b); end
    tests++; if (p_if.avg_diff !== 13'h1ffe) begin fails++;
      $display("FAIL pt_diff: got %0h expected 1ffe", p_if.avg_diff); end
    step();
    tests++; if (p_if.avg_valid !== 1'b0) begin fails++;
      $display("FAIL pt_accepted: got %0d expected 0", p_if.avg_valid); end
  endtask

  initial begin
    s_if.new_data  = 1'b0;
    s_if.data_a    = '0;
    s_if.data_b    = '0;
    s_if.avg_ready = 1'b0;
    test_reset();
    test_basic();
    test_extremes();
    test_held_level();
    test_overrun();
    test_enable_and_async_reset();
    test_back_to_back();
    test_passthrough();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
